// File: rtl/johnson_pkg.sv
// Shared types and the Johnson code decode function for Johnson-counter consumers.
package johnson_pkg;

   // Widest Johnson register the shared decode function supports.
   localparam int JC_MAX_W = 16;
   localparam int JC_IDX_W = $clog2(2 * JC_MAX_W);

   // Default register width and the matching sequence length.
   localparam int JC_WIDTH = 4;
   localparam int NSTATES  = 2 * JC_WIDTH;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } jc_state_t;

   typedef struct packed {
      logic                legal;
      logic [JC_IDX_W-1:0] idx;
   } jc_dec_t;

   // Match the code against every legal pattern of a 'width'-bit Johnson sequence.
   // Indices 0..width fill ones from the bottom; later indices clear ones from the bottom.
   function automatic jc_dec_t jc_decode(input logic [JC_MAX_W-1:0] code, input int width);
      jc_dec_t             r;
      logic [JC_MAX_W-1:0] pat;
      logic [JC_MAX_W-1:0] wmask;
      r     = '0;
      wmask = (JC_MAX_W'(1) << width) - JC_MAX_W'(1);
      for (int k = 0; k < 2 * JC_MAX_W; k++) begin
         if (k < 2 * width) begin
            if (k <= width)
               pat = (JC_MAX_W'(1) << k) - JC_MAX_W'(1);
            else
               pat = wmask & ~((JC_MAX_W'(1) << (k - width)) - JC_MAX_W'(1));
            if (!r.legal && (code == pat)) begin
               r.legal = 1'b1;
               r.idx   = JC_IDX_W'(k);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/johnson_phase_decoder_if.sv
// Sample input and decoded-phase/status outputs of the Johnson phase decoder.
interface johnson_phase_decoder_if #(
   parameter int WIDTH = 4,
   parameter int ERR_W = 8
);
   localparam int NST = 2 * WIDTH;
   localparam int IW  = $clog2(NST);

   logic             en;
   logic [WIDTH-1:0] count;
   logic [NST-1:0]   phase_onehot;
   logic [IW-1:0]    phase_idx;
   logic             phase_valid;
   logic             locked;
   logic             err_pulse;
   logic             resync_req;
   logic [ERR_W-1:0] err_count;

   modport master (
      output en, count,
      input  phase_onehot, phase_idx, phase_valid, locked, err_pulse, resync_req, err_count
   );

   modport slave (
      input  en, count,
      output phase_onehot, phase_idx, phase_valid, locked, err_pulse, resync_req, err_count
   );
endinterface

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder: legality, binary index and one-hot phase.
module johnson_decode
   import johnson_pkg::*;
#(
   parameter int WIDTH = 4,
   localparam int NST  = 2 * WIDTH,
   localparam int IW   = $clog2(NST)
) (
   input  logic [WIDTH-1:0] count,
   output logic             legal,
   output logic [IW-1:0]    idx,
   output logic [NST-1:0]   onehot
);

   jc_dec_t dec;

   // Decode the code; an illegal code yields an all-zero one-hot and index 0.
   always_comb begin
      dec    = jc_decode(JC_MAX_W'(count), WIDTH);
      legal  = dec.legal;
      idx    = IW'(dec.idx);
      onehot = dec.legal ? (NST'(1) << idx) : '0;
   end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Decodes upstream Johnson samples, checks sequence stepping, tracks lock and
// requests a resync when a locked stream goes bad.
module johnson_phase_decoder
   import johnson_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 2,
   parameter int ALLOW_HOLD = 0,
   parameter int ERR_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   johnson_phase_decoder_if.slave  bus
);

   localparam int NST = 2 * WIDTH;
   localparam int IW  = $clog2(NST);
   localparam int GW  = $clog2(LOCK_CNT + 1);
   localparam int MW  = $clog2(UNLOCK_CNT + 1);

   localparam logic [IW-1:0] LAST_IDX = IW'(NST - 1);
   localparam logic [GW-1:0] GOOD_M1  = GW'(LOCK_CNT - 1);
   localparam logic [MW-1:0] MISS_M1  = MW'(UNLOCK_CNT - 1);

   logic             dec_legal;
   logic [IW-1:0]    dec_idx;
   logic [NST-1:0]   dec_onehot;

   logic [NST-1:0]   onehot_q;
   logic [IW-1:0]    idx_q;
   logic             valid_q;
   logic             pulse_q;
   logic             resync_q;
   logic [ERR_W-1:0] err_cnt_q;

   logic [IW-1:0]    prev_idx_q;
   logic             prev_valid_q;

   jc_state_t        state_q, state_d;
   logic [GW-1:0]    good_q, good_d;
   logic [MW-1:0]    miss_q, miss_d;
   logic             unlock;

   logic [IW-1:0]    next_idx;
   logic             step_ok;
   logic             good_ev;
   logic             bad_ev;

   johnson_decode #(.WIDTH(WIDTH)) u_dec (
      .count  (bus.count),
      .legal  (dec_legal),
      .idx    (dec_idx),
      .onehot (dec_onehot)
   );

   // Classify the sample: good step, bad step/illegal code, or neither (seed / idle).
   always_comb begin
      next_idx = (prev_idx_q == LAST_IDX) ? '0 : prev_idx_q + 1'b1;
      step_ok  = (dec_idx == next_idx) || ((ALLOW_HOLD != 0) && (dec_idx == prev_idx_q));
      good_ev  = bus.en & dec_legal & prev_valid_q & step_ok;
      bad_ev   = bus.en & (~dec_legal | (prev_valid_q & ~step_ok));
   end

   // Lock FSM next state and run counters; counters hold when no event occurs.
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      miss_d  = miss_q;
      unlock  = 1'b0;
      case (state_q)
         HUNT: begin
            if (good_ev) begin
               if (good_q == GOOD_M1) begin
                  state_d = LOCKED;
                  good_d  = '0;
                  miss_d  = '0;
               end else begin
                  good_d = good_q + 1'b1;
               end
            end else if (bad_ev) begin
               good_d = '0;
            end
         end
         LOCKED: begin
            if (good_ev) begin
               miss_d = '0;
            end else if (bad_ev) begin
               if (miss_q == MISS_M1) begin
                  state_d = HUNT;
                  good_d  = '0;
                  miss_d  = '0;
                  unlock  = 1'b1;
               end else begin
                  miss_d = miss_q + 1'b1;
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // FSM state and run counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= HUNT;
         good_q  <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
         miss_q  <= miss_d;
      end
   end

   // Previous-sample tracking; an illegal code drops the reference so the next legal one re-seeds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_idx_q   <= '0;
         prev_valid_q <= 1'b0;
      end else if (bus.en) begin
         if (dec_legal) begin
            prev_idx_q   <= dec_idx;
            prev_valid_q <= 1'b1;
         end else begin
            prev_valid_q <= 1'b0;
         end
      end
   end

   // Registered decode outputs; index holds across idle cycles and illegal codes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         onehot_q <= '0;
         idx_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= bus.en & dec_legal;
         if (bus.en) begin
            onehot_q <= dec_onehot;
            if (dec_legal)
               idx_q <= dec_idx;
         end
      end
   end

   // Error pulse, resync pulse and saturating error counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pulse_q   <= 1'b0;
         resync_q  <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         pulse_q  <= bad_ev;
         resync_q <= unlock;
         if (bad_ev && (err_cnt_q != {ERR_W{1'b1}}))
            err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   assign bus.phase_onehot = onehot_q;
   assign bus.phase_idx    = idx_q;
   assign bus.phase_valid  = valid_q;
   assign bus.locked       = (state_q == LOCKED);
   assign bus.err_pulse    = pulse_q;
   assign bus.resync_req   = resync_q;
   assign bus.err_count    = err_cnt_q;

endmodule
